fifo_pop_serializer: RTL and testbench
======================================

Name: fifo_pop_serializer

Overview:
Reader for the codebase FIFOs' pop interface. Pops IN_WIDTH-bit words from a first-word-fall-through FIFO and emits each word as IN_WIDTH/OUT_WIDTH narrower chunks on a push/push_ready stream. Sits on the read side of the clock-crossing and sync FIFOs and feeds narrow sinks such as byte-wide host pipes and serial links. Single clock domain.

Parameters:
IN_WIDTH, 32, width of the popped FIFO word
OUT_WIDTH, 8, width of each emitted chunk; IN_WIDTH must be an integer multiple of OUT_WIDTH, with ratio RATIO = IN_WIDTH/OUT_WIDTH >= 2
CNT_WIDTH, 2, chunk index width; must equal ceil(log2(RATIO))

Ports:
clk  input  1  block clock
rst_n  input  1  reset; one clock; asynchronous assert, active-low
fifo_pop  output  1  pop strobe to the FIFO; the FIFO consumes a word when fifo_pop and fifo_pop_ready are both high
fifo_pop_data  input  IN_WIDTH  FIFO head word, valid whenever fifo_pop_ready is high (fall-through)
fifo_pop_ready  input  1  FIFO not empty
out_push  output  1  chunk valid; a transfer occurs when out_push and out_push_ready are both high
out_data  output  OUT_WIDTH  current chunk
out_push_ready  input  1  downstream can accept
busy  output  1  high while a word is held (state SEND)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = EMPTY, chunk index cnt = 0, holding register = 0.
  - out_push = 0, out_data = 0, busy = 0.
  - fifo_pop is forced to 0 while rst_n is low.
- States: EMPTY, SEND.
- EMPTY:
  - fifo_pop = fifo_pop_ready (combinational).
  - When fifo_pop_ready is high, the rising edge captures fifo_pop_data into the holding register, sets cnt = 0, and moves to SEND.
- SEND:
  - out_push = 1; busy = 1.
  - out_data = chunk cnt; default order is MSB first, so chunk 0 = hold[IN_WIDTH-1 -: OUT_WIDTH].
  - On out_push && out_push_ready with cnt < RATIO-1: cnt increments by 1.
  - On acceptance with cnt == RATIO-1 (last chunk):
    - fifo_pop = fifo_pop_ready in the same cycle.
    - If the FIFO is non-empty: capture the next word, set cnt = 0, stay in SEND. There is no bubble.
    - Otherwise go to EMPTY.
  - fifo_pop is 0 in SEND except in this last-chunk-accept cycle.
- Stall behaviour: while out_push is high and out_push_ready is low, out_data, cnt and the holding register are stable. The valid signal is never withdrawn once asserted.
- Latency: word at the FIFO head in cycle N (state EMPTY) gives its first chunk valid in cycle N+1.
- Throughput: one chunk per cycle sustained, i.e. one word per RATIO cycles.
- out_data is registered-path only: driven from the holding register plus a mux on cnt, with no combinational path from fifo_pop_data.
- No combinational path from out_push_ready to out_push.
- cnt never exceeds RATIO-1. For a non-power-of-two RATIO it wraps explicitly to 0.
- Reset mid-word: the partially sent word is discarded; no further chunks are emitted for it.

Optional Feature:
SERIALIZER_LSB_FIRST_EN
- Defined: chunk order is LSB first, so chunk 0 = hold[OUT_WIDTH-1:0] and chunk k = hold[k*OUT_WIDTH +: OUT_WIDTH].
- Undefined: MSB-first order as above.
- Handshake and timing are identical in both builds.

Test Plan:
- FIFO holds 0xA1B2C3D4, out_push_ready=1 -> fifo_pop high for 1 cycle; next 4 cycles out_data = A1, B2, C3, D4 with out_push=1; then out_push=0, busy=0.
- Two words 0x11223344, 0x55667788 present, out_push_ready=1 -> 8 consecutive chunks 11..88 with no gap; second fifo_pop coincides with the cycle that accepts chunk 44.
- Word 0xDEADBEEF; out_push_ready dropped for 3 cycles after chunk AD is accepted -> out_data holds BE with out_push=1 for those 3 cycles; then BE, EF complete; exactly one pop.
- fifo_pop_ready=0 for 20 cycles -> fifo_pop=0, out_push=0, busy=0 throughout.
- rst_n pulsed low while chunk index is 2 of 0xCAFEF00D -> out_push, busy and fifo_pop drop immediately (asynchronous); after release no F0/0D chunks appear, and the next FIFO word starts at chunk 0.
- Build with SERIALIZER_LSB_FIRST_EN, word 0xA1B2C3D4 -> out_data = D4, C3, B2, A1.

Source files
------------

// File: rtl/fifo_pop_serializer.sv
// fifo_pop_serializer: pops wide first-word-fall-through FIFO words and emits them as OUT_WIDTH chunks.
// Define SERIALIZER_LSB_FIRST_EN for LSB-first chunk order; the default order is MSB first.
module fifo_pop_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_pop,
  input  logic [IN_WIDTH-1:0]  fifo_pop_data,
  input  logic                 fifo_pop_ready,
  output logic                 out_push,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_push_ready,
  output logic                 busy
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  typedef enum logic {EMPTY, SEND} state_t;
  state_t r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [IN_WIDTH-1:0] r_hold;
  logic [OUT_WIDTH-1:0] w_chunk [RATIO];
  logic w_acc, w_last, w_pop;
  always_comb begin
    w_acc  = r_state == SEND && out_push_ready;
    w_last = w_acc && r_cnt == CNT_WIDTH'(RATIO - 1);
    w_pop  = fifo_pop_ready && (r_state == EMPTY || w_last);
    w_next = w_pop ? SEND : w_last ? EMPTY : r_state;
  end
  for (genvar g = 0; g < RATIO; g++) begin : g_chunk
`ifdef SERIALIZER_LSB_FIRST_EN
    assign w_chunk[g] = r_hold[g*OUT_WIDTH +: OUT_WIDTH];
`else
    assign w_chunk[g] = r_hold[(RATIO-1-g)*OUT_WIDTH +: OUT_WIDTH];
`endif
  end
  // the pop strobe is gated by rst_n so it drops the moment reset asserts
  assign fifo_pop = w_pop && rst_n;
  assign out_push = r_state == SEND;
  assign busy     = out_push;
  assign out_data = w_chunk[r_cnt];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_pop || w_last) ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
      if (w_pop) r_hold <= fifo_pop_data;
    end
  end
endmodule

// File: tb/tb_fifo_pop_serializer.sv
// tb_fifo_pop_serializer: directed table, hand sequences and random traffic against a queue-based model.
module tb_fifo_pop_serializer;
  logic clk = 0, rst_n = 0;
  logic fifo_pop, fifo_pop_ready = 0, out_push, out_push_ready = 1, busy;
  logic [31:0] fifo_pop_data = 0;
  logic [7:0] out_data;
  int checks = 0, errors = 0, pops = 0;
  logic [31:0] q[$];
  logic [7:0] exp_q[$];
  logic r_stall = 0;
  logic [7:0] r_prev = 0;
  typedef struct {
    logic [31:0] word;
    int stall_at;
    int stall_len;
    logic [7:0] e [4];
  } row_t;
  row_t rows [5];

  fifo_pop_serializer dut (
    .clk(clk), .rst_n(rst_n), .fifo_pop(fifo_pop), .fifo_pop_data(fifo_pop_data),
    .fifo_pop_ready(fifo_pop_ready), .out_push(out_push), .out_data(out_data),
    .out_push_ready(out_push_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chunk(input logic [31:0] w, input int k);
`ifdef SERIALIZER_LSB_FIRST_EN
    return 8'(w >> (8 * k));
`else
    return 8'(w >> (8 * (3 - k)));
`endif
  endfunction

  function automatic logic [7:0] row_chunk(input row_t r, input int k);
`ifdef SERIALIZER_LSB_FIRST_EN
    return r.e[3 - k];
`else
    return r.e[k];
`endif
  endfunction

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic upd();
    fifo_pop_ready = q.size() > 0;
    fifo_pop_data  = q.size() > 0 ? q[0] : 32'h0;
  endtask

  task automatic tick();
    logic popped;
    @(negedge clk);
    popped = fifo_pop && fifo_pop_ready;
    chk("busy_eq_push", busy == out_push, {31'b0, busy}, {31'b0, out_push});
    if (!fifo_pop_ready) chk("pop_when_empty", !fifo_pop, {31'b0, fifo_pop}, 32'h0);
    if (r_stall) chk("stall_hold", out_push && out_data == r_prev, {23'b0, out_push, out_data}, {24'h1, r_prev});
    if (out_push && out_push_ready) begin
      chk("chunk", exp_q.size() > 0 && out_data == (exp_q.size() > 0 ? exp_q[0] : 8'h0),
          {24'b0, out_data}, {24'b0, exp_q.size() > 0 ? exp_q[0] : 8'h0});
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (popped) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(chunk(q[0], k));
      pops++;
    end
    r_stall = out_push && !out_push_ready;
    r_prev  = out_data;
    @(posedge clk);
    #1;
    if (popped) void'(q.pop_front());
    upd();
  endtask

  initial begin
    rows[0] = '{32'hA1B2C3D4, 4, 0, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    rows[1] = '{32'hDEADBEEF, 2, 3, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    rows[2] = '{32'h00000000, 4, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    rows[3] = '{32'hFFFFFFFF, 0, 1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    rows[4] = '{32'h0F1E2D3C, 3, 2, '{8'h0F, 8'h1E, 8'h2D, 8'h3C}};
    q.push_back(32'h99999999);
    upd();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", !fifo_pop, {31'b0, fifo_pop}, 32'h0);
    chk("rst_push", !out_push, {31'b0, out_push}, 32'h0);
    chk("rst_busy", !busy, {31'b0, busy}, 32'h0);
    chk("rst_data", out_data == 8'h0, {24'b0, out_data}, 32'h0);
    q.delete();
    upd();
    rst_n = 1;
    #1;
    foreach (rows[i]) begin
      int p0;
      q.push_back(rows[i].word);
      upd();
      #1;
      chk("row_pop", fifo_pop, {31'b0, fifo_pop}, 32'h1);
      p0 = pops;
      tick();
      for (int k = 0; k < 4; k++) begin
        if (k == rows[i].stall_at) begin
          out_push_ready = 0;
          for (int s = 0; s < rows[i].stall_len; s++) begin
            chk("row_stall", out_push && out_data == row_chunk(rows[i], k),
                {23'b0, out_push, out_data}, {24'h1, row_chunk(rows[i], k)});
            tick();
          end
          out_push_ready = 1;
        end
        chk("row_chunk", out_push && out_data == row_chunk(rows[i], k),
            {23'b0, out_push, out_data}, {24'h1, row_chunk(rows[i], k)});
        tick();
      end
      chk("row_done_push", !out_push, {31'b0, out_push}, 32'h0);
      chk("row_done_busy", !busy, {31'b0, busy}, 32'h0);
      chk("row_pops", pops - p0 == 1, pops - p0, 32'h1);
    end
    q.push_back(32'h11223344);
    q.push_back(32'h55667788);
    upd();
    tick();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = chunk(k < 4 ? 32'h11223344 : 32'h55667788, k % 4);
      chk("b2b_chunk", out_push && out_data == e, {23'b0, out_push, out_data}, {24'h1, e});
      chk("b2b_pop", fifo_pop == (k == 3), {31'b0, fifo_pop}, {31'b0, k == 3});
      tick();
    end
    chk("b2b_done", !out_push && !busy, {30'b0, out_push, busy}, 32'h0);
    for (int c = 0; c < 20; c++) begin
      chk("idle", !fifo_pop && !out_push && !busy, {29'b0, fifo_pop, out_push, busy}, 32'h0);
      tick();
    end
    q.push_back(32'hCAFEF00D);
    q.push_back(32'h12345678);
    upd();
    repeat (3) tick();
    chk("pre_rst_chunk", out_push && out_data == chunk(32'hCAFEF00D, 2),
        {23'b0, out_push, out_data}, {24'h1, chunk(32'hCAFEF00D, 2)});
    rst_n = 0;
    #1;
    chk("async_rst", !fifo_pop && !out_push && !busy, {29'b0, fifo_pop, out_push, busy}, 32'h0);
    exp_q.delete();
    r_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    tick();
    chk("post_rst_chunk0", out_push && out_data == chunk(32'h12345678, 0),
        {23'b0, out_push, out_data}, {24'h1, chunk(32'h12345678, 0)});
    for (int c = 0; c < 1500; c++) begin
      out_push_ready = $urandom_range(0, 3) != 0;
      if (q.size() < 4 && $urandom_range(0, 2) == 0) begin
        q.push_back($urandom);
        upd();
      end
      #1;
      tick();
    end
    out_push_ready = 1;
    for (int c = 0; c < 200 && (q.size() > 0 || exp_q.size() > 0 || out_push); c++) tick();
    chk("drain", q.size() == 0 && exp_q.size() == 0 && !out_push,
        {q.size() + exp_q.size()}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
